pwm_capture: RTL and testbench

Measures an incoming PWM waveform and reports its period and high time in clock cycles. It is the receive-side counterpart of the PWM comparator and sits on the feedback/monitor path. It lets firmware or a loop-back checker confirm that a generated PWM, or one arriving from an external pin, has the expected period and duty. For a source built from a free-running counter of P steps and a duty value D, the block reports `period = P` and `duty = D`.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_sync_edge.sv | 33 +++
 rtl/pwm_capture.sv | 97 +++++++++
 tb/tb_pwm_capture.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM generator and the PWM capture path.
//   PWM_WIDTH   - default counter / result width
//   pwm_state_e - capture FSM states (IDLE, ARM, MEAS)
package pwm_pkg;

   localparam int PWM_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // disabled, counters held at 0
      ARM  = 2'd1,   // waiting for a first rising edge to anchor the period
      MEAS = 2'd2    // anchored, every rising edge closes one period
   } pwm_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: brings an asynchronous PWM input into the clk domain and
// flags its rising edges.
//   clk, rst_n  - clock, async active-low reset
//   pwm_in      - raw asynchronous PWM input
//   s           - synchronized level (last synchronizer stage)
//   rise        - s went 0->1 this cycle (s & ~s_d)
module pwm_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_in,
   output logic s,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         s_d    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         s_d    <= sync_q[SYNC_STAGES-1];
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_d;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an incoming PWM in clk cycles.
//   clk, rst_n   - clock, async active-low reset
//   enable       - level-sensitive measurement enable
//   pwm_in       - asynchronous PWM input
//   period, duty - last measured period / high time (held between reports)
//   valid        - one-cycle pulse when period/duty update
//   timeout      - one-cycle pulse when no rising edge for 2^WIDTH-1 cycles
//   stuck_level  - synced input level captured at the last timeout
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int WIDTH       = PWM_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             pwm_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] duty,
   output logic             valid,
   output logic             timeout,
   output logic             stuck_level
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic             s;
   logic             rise;
   pwm_state_e       state;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] hcnt;

   pwm_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .s      (s),
      .rise   (rise)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         hcnt        <= '0;
         period      <= '0;
         duty        <= '0;
         valid       <= 1'b0;
         timeout     <= 1'b0;
         stuck_level <= 1'b0;
      end else begin
         valid   <= 1'b0;
         timeout <= 1'b0;
         if (!enable) begin
            // disable overrides everything, including a coincident rise
            state <= IDLE;
            cnt   <= '0;
            hcnt  <= '0;
         end else begin
            unique case (state)
               IDLE: state <= ARM;
               ARM, MEAS: begin
                  if (rise) begin
                     // rise wins over saturation, so a period of exactly
                     // CNT_MAX is still reported
                     if (state == MEAS) begin
                        period <= cnt;
                        duty   <= hcnt;
                        valid  <= 1'b1;
                     end
                     state <= MEAS;
                     cnt   <= ONE;
                     hcnt  <= ONE;
                  end else if (cnt == CNT_MAX) begin
                     // no edge for a full counter span: input is stuck
                     timeout     <= 1'b1;
                     stuck_level <= s;
                     state       <= ARM;
                     cnt         <= '0;
                     hcnt        <= '0;
                  end else begin
                     // cnt never passes CNT_MAX: the branch above catches it
                     cnt <= cnt + ONE;
                     if (s && hcnt != CNT_MAX) hcnt <= hcnt + ONE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture (WIDTH=8, SYNC_STAGES=2).
module tb_pwm_capture;

   localparam int W  = 8;
   localparam int SS = 2;
   localparam int LAT = SS + 1;   // input change -> counters/valid edge

   logic         clk = 1'b0;
   logic         rst_n;
   logic         enable;
   logic         pwm_in;
   logic [W-1:0] period;
   logic [W-1:0] duty;
   logic         valid;
   logic         timeout;
   logic         stuck_level;

   int cyc    = 0;
   int n_chk  = 0;
   int n_pass = 0;
   int r_save;
   int v_per[$], v_duty[$], v_cyc[$], t_cyc[$], t_lvl[$], r_cyc[$];

   pwm_capture #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .pwm_in      (pwm_in),
      .period      (period),
      .duty        (duty),
      .valid       (valid),
      .timeout     (timeout),
      .stuck_level (stuck_level)
   );

   always #5 clk = ~clk;

   // cyc == n between edge n and edge n+1
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid) begin
         v_per.push_back(int'(period));
         v_duty.push_back(int'(duty));
         v_cyc.push_back(cyc);
      end
      if (timeout) begin
         t_cyc.push_back(cyc);
         t_lvl.push_back(int'(stuck_level));
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
   endtask

   function automatic int at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic clr();
      v_per.delete(); v_duty.delete(); v_cyc.delete();
      t_cyc.delete(); t_lvl.delete(); r_cyc.delete();
   endtask

   // hold one level for one cycle, logging the cycle of each 0->1 drive
   task automatic drive(input logic lvl);
      if (lvl && !pwm_in) r_cyc.push_back(cyc);
      pwm_in = lvl;
      @(negedge clk);
   endtask

   task automatic hold(input logic lvl, input int n);
      for (int i = 0; i < n; i++) drive(lvl);
   endtask

   task automatic run_pwm(input int hi, input int per, input int n);
      for (int k = 0; k < n; k++)
         for (int i = 0; i < per; i++) drive(i < hi);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_period", period, 0);
      chk("rst_duty", duty, 0);
      chk("rst_valid", valid, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_stuck", stuck_level, 0);
      rst_n = 1'b1;
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);

      // steady 100/25: first rise only arms
      clr(); run_pwm(25, 100, 4);
      chk("steady_nvalid", v_cyc.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk("steady_period", at(v_per, i), 100);
         chk("steady_duty", at(v_duty, i), 25);
         chk("steady_lat", at(v_cyc, i), at(r_cyc, i + 1) + LAT);
      end

      // duty step 25 -> 60: first report closes the last 25% period
      clr(); run_pwm(60, 100, 3);
      chk("step_nvalid", v_cyc.size(), 3);
      chk("step_duty0", at(v_duty, 0), 25);
      chk("step_duty1", at(v_duty, 1), 60);
      chk("step_duty2", at(v_duty, 2), 60);
      for (int i = 0; i < 3; i++) chk("step_period", at(v_per, i), 100);

      // stuck high: timeout 255 cycles after the rise is taken
      clr(); hold(1'b1, 300);
      r_save = at(r_cyc, 0);
      chk("sthi_nvalid", v_cyc.size(), 1);
      chk("sthi_vper", at(v_per, 0), 100);
      chk("sthi_vduty", at(v_duty, 0), 60);
      chk("sthi_nto", t_cyc.size(), 1);
      chk("sthi_to_cyc", at(t_cyc, 0), r_save + LAT + 255);
      chk("sthi_lvl", at(t_lvl, 0), 1);
      chk("sthi_period_hold", period, 100);
      chk("sthi_duty_hold", duty, 60);

      // stuck low: ARM restarts from 0, next timeout 256 cycles later
      clr(); hold(1'b0, 300);
      chk("stlo_nvalid", v_cyc.size(), 0);
      chk("stlo_nto", t_cyc.size(), 1);
      chk("stlo_to_cyc", at(t_cyc, 0), r_save + LAT + 255 + 256);
      chk("stlo_lvl", at(t_lvl, 0), 0);
      chk("stlo_stuck", stuck_level, 0);
      chk("stlo_period_hold", period, 100);

      // enable drop coincident with rise
      clr(); run_pwm(25, 100, 2);
      drive(1'b1); drive(1'b1);
      enable = 1'b0;               // low at the edge that sees rise
      for (int i = 2; i < 100; i++) drive(i < 25);
      chk("en_nvalid", v_cyc.size(), 1);
      chk("en_vper", at(v_per, 0), 100);
      chk("en_period_hold", period, 100);
      chk("en_duty_hold", duty, 25);
      chk("en_cnt", dut.cnt, 0);
      chk("en_hcnt", dut.hcnt, 0);
      enable = 1'b1;
      clr(); run_pwm(25, 100, 3);
      chk("reen_nvalid", v_cyc.size(), 2);
      chk("reen_lat", at(v_cyc, 0), at(r_cyc, 1) + LAT);
      chk("reen_period", at(v_per, 0), 100);
      chk("reen_duty", at(v_duty, 0), 25);

      // async reset mid-period
      run_pwm(25, 100, 1);
      for (int i = 0; i < 50; i++) drive(i < 25);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_period", period, 0);
      chk("arst_duty", duty, 0);
      chk("arst_valid", valid, 0);
      chk("arst_stuck", stuck_level, 0);
      clr();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      hold(1'b0, 50);
      run_pwm(25, 100, 3);
      chk("arst_nvalid", v_cyc.size(), 2);
      chk("arst_lat", at(v_cyc, 0), at(r_cyc, 1) + LAT);
      chk("arst_vper", at(v_per, 0), 100);

      // period exactly 2^W-1: rise beats saturation
      clr(); run_pwm(10, 255, 3);
      chk("sat_nvalid", v_cyc.size(), 3);
      chk("sat_per0", at(v_per, 0), 100);
      chk("sat_per1", at(v_per, 1), 255);
      chk("sat_duty1", at(v_duty, 1), 10);
      chk("sat_per2", at(v_per, 2), 255);
      chk("sat_duty2", at(v_duty, 2), 10);
      chk("sat_nto", t_cyc.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
